// File: rtl/dadda_mul_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dadda_mul_arbiter (with Dadda_16b)
//  Brief    : Round-robin sequencer sharing one 16x16 multiplier among NREQ
//             requesters; registered operands in, registered tagged product out.
//  Revision : 1.0  initial release
// ============================================================================

module Dadda_16b (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic [31:0] o_y
);
    logic [31:0] w_pp [16];
    logic [31:0] w_s1 [11];
    logic [31:0] w_s2 [8];
    logic [31:0] w_s3 [6];
    logic [31:0] w_s4 [4];
    logic [31:0] w_s5 [3];
    logic [31:0] w_s6 [2];
    logic [63:0] w_t;

    function automatic logic [63:0] csa(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] z);
        logic [31:0] s;
        logic [31:0] c;
        s = x ^ y ^ z;
        c = ((x & y) | (x & z) | (y & z)) << 1;
        return {s, c};
    endfunction

    // Carry-save reduction 16 -> 11 -> 8 -> 6 -> 4 -> 3 -> 2 rows, then one CPA
    always_comb begin
        w_t = '0;
        for (int i = 0; i < 16; i++) begin
            w_pp[i] = {16'd0, i_a & {16{i_b[i]}}} << i;
        end
        for (int k = 0; k < 5; k++) begin
            w_t = csa(w_pp[3*k], w_pp[3*k+1], w_pp[3*k+2]);
            w_s1[2*k]   = w_t[63:32];
            w_s1[2*k+1] = w_t[31:0];
        end
        w_s1[10] = w_pp[15];
        for (int k = 0; k < 3; k++) begin
            w_t = csa(w_s1[3*k], w_s1[3*k+1], w_s1[3*k+2]);
            w_s2[2*k]   = w_t[63:32];
            w_s2[2*k+1] = w_t[31:0];
        end
        w_s2[6] = w_s1[9];
        w_s2[7] = w_s1[10];
        for (int k = 0; k < 2; k++) begin
            w_t = csa(w_s2[3*k], w_s2[3*k+1], w_s2[3*k+2]);
            w_s3[2*k]   = w_t[63:32];
            w_s3[2*k+1] = w_t[31:0];
        end
        w_s3[4] = w_s2[6];
        w_s3[5] = w_s2[7];
        for (int k = 0; k < 2; k++) begin
            w_t = csa(w_s3[3*k], w_s3[3*k+1], w_s3[3*k+2]);
            w_s4[2*k]   = w_t[63:32];
            w_s4[2*k+1] = w_t[31:0];
        end
        w_t     = csa(w_s4[0], w_s4[1], w_s4[2]);
        w_s5[0] = w_t[63:32];
        w_s5[1] = w_t[31:0];
        w_s5[2] = w_s4[3];
        w_t     = csa(w_s5[0], w_s5[1], w_s5[2]);
        w_s6[0] = w_t[63:32];
        w_s6[1] = w_t[31:0];
        o_y     = w_s6[0] + w_s6[1];
    end
endmodule

module dadda_mul_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [16*NREQ-1:0]   req_a,
    input  logic [16*NREQ-1:0]   req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_y
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t         r_state_q, w_state_d;
    logic [IDW-1:0] r_ptr_q, w_ptr_d;
    logic [IDW-1:0] r_id_q, w_id_d;
    logic [15:0]    r_op_a_q, w_op_a_d;
    logic [15:0]    r_op_b_q, w_op_b_d;
    logic [31:0]    r_y_q, w_y_d;
    logic [31:0]    w_prod;
    logic [IDW:0]   w_pick;
    logic [IDW-1:0] w_gnt;
    logic           w_any;
    logic [15:0]    w_sel_a, w_sel_b;

    // Returns {found, index} of the first set bit at or above p, with wrap.
    function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] v,
                                             input logic [IDW-1:0]  p);
        logic [IDW:0] res;
        res = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            for (int j = 0; j < NREQ; j++) begin
                if (j == (int'(p) + k) % NREQ && v[j]) begin
                    res = {1'b1, IDW'(j)};
                end
            end
        end
        return res;
    endfunction

    Dadda_16b u_mul (
        .i_a (r_op_a_q),
        .i_b (r_op_b_q),
        .o_y (w_prod)
    );

    always_comb begin
        w_pick  = rr_pick(req_valid, r_ptr_q);
        w_any   = w_pick[IDW];
        w_gnt   = w_pick[IDW-1:0];
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt == IDW'(i)) begin
                w_sel_a = req_a[16*i +: 16];
                w_sel_b = req_b[16*i +: 16];
            end
        end

        w_state_d = r_state_q;
        w_ptr_d   = r_ptr_q;
        w_id_d    = r_id_q;
        w_op_a_d  = r_op_a_q;
        w_op_b_d  = r_op_b_q;
        w_y_d     = r_y_q;
        req_ready = '0;

        case (r_state_q)
            S_IDLE: begin
                if (w_any) begin
                    req_ready = NREQ'(1) << w_gnt;
                    w_op_a_d  = w_sel_a;
                    w_op_b_d  = w_sel_b;
                    w_id_d    = w_gnt;
                    w_ptr_d   = (int'(w_gnt) == NREQ - 1) ? '0 : w_gnt + 1'b1;
                    w_state_d = S_MUL;
                end
            end
            S_MUL: begin
                w_y_d     = w_prod;
                w_state_d = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_d = S_IDLE;
                end
            end
            default: w_state_d = S_IDLE;
        endcase

        // A grant shown during reset would be a lie: nothing gets latched.
        if (rst) begin
            req_ready = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= S_IDLE;
            r_ptr_q   <= '0;
            r_id_q    <= '0;
            r_op_a_q  <= '0;
            r_op_b_q  <= '0;
            r_y_q     <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_ptr_q   <= w_ptr_d;
            r_id_q    <= w_id_d;
            r_op_a_q  <= w_op_a_d;
            r_op_b_q  <= w_op_b_d;
            r_y_q     <= w_y_d;
        end
    end

    assign rsp_valid = (r_state_q == S_RESP);
    assign rsp_id    = r_id_q;
    assign rsp_y     = r_y_q;
endmodule

`default_nettype wire

// File: tb/tb_dadda_mul_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dadda_mul_arbiter
//  Brief    : Directed/random bench with a response scoreboard and monitor.
//  Revision : 1.0  initial release
// ============================================================================

module tb_dadda_mul_arbiter;
    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [31:0] rsp_y;

    logic        man_ready;
    logic        rnd_ready;
    logic        rand_mode;
    int          cyc;
    int          n_checks;
    int          n_fail;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] y;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    assign rsp_ready = rand_mode ? rnd_ready : man_ready;

    dadda_mul_arbiter #(.NREQ(4), .IDW(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_y     (rsp_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1 rnd_ready = ($urandom_range(0, 2) != 0);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Every response handshake must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rsp: got id %0d y %0h, expected none", rsp_id, rsp_y);
            end else begin
                mon_e = sb.pop_front();
                check("rsp_id", 64'(rsp_id), 64'(mon_e.id));
                check("rsp_y", 64'(rsp_y), 64'(mon_e.y));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accept edge.
    task automatic issue(input int id, input logic [15:0] a, input logic [15:0] b,
                         input bit push, input logic [31:0] y, output int acc);
        bit got;
        got = 1'b0;
        acc = -1;
        req_a[16*id +: 16] = a;
        req_b[16*id +: 16] = b;
        req_valid[id] = 1'b1;
        for (int n = 0; n < 300 && !got; n++) begin
            @(negedge clk);
            if (req_ready[id]) begin
                got = 1'b1;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        if (!got) begin
            check("grant_timeout", 64'(req_ready), 64'(4'b1 << id));
        end else begin
            check("grant_onehot", 64'(req_ready), 64'(4'b1 << id));
            if (push) sb.push_back('{id: 2'(id), y: y});
            acc = cyc;
        end
        @(posedge clk);
        #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int last;
        bit got;
        logic [15:0] ra, rb;
        int rid;

        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        rand_mode = 1'b0;
        man_ready = 1'b1;
        req_a     = '0;
        req_b     = '0;
        req_valid = 4'b0101;

        // Reset state, with requests pending to confirm grants are suppressed
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_y", 64'(rsp_y), 64'd0);
        check("rst_rsp_id", 64'(rsp_id), 64'd0);
        @(posedge clk);
        #1;
        req_valid = '0;
        rst = 1'b0;

        // Single request: latency 2, one-cycle response pulse
        issue(1, 16'h1234, 16'h5678, 1'b1, 32'h06260060, acc);
        @(negedge clk);
        check("t1_mul_valid", 64'(rsp_valid), 64'd0);
        check("t1_mul_ready", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("t1_latency", 64'(cyc - acc), 64'd2);
        check("t1_valid", 64'(rsp_valid), 64'd1);
        check("t1_id", 64'(rsp_id), 64'd1);
        check("t1_y", 64'(rsp_y), 64'h06260060);
        @(posedge clk); #1;
        @(negedge clk);
        check("t1_pulse_end", 64'(rsp_valid), 64'd0);
        @(posedge clk); #1;

        // Fairness from a fresh pointer
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_a[16*i +: 16] = 16'(i + 1);
            req_b[16*i +: 16] = 16'(i + 1);
        end
        req_valid = 4'hF;
        last = 0;
        for (int k = 0; k < 5; k++) begin
            got = 1'b0;
            for (int n = 0; n < 20 && !got; n++) begin
                @(negedge clk);
                if (req_ready != 0) got = 1'b1;
                else begin @(posedge clk); #1; end
            end
            check("fair_grant", 64'(req_ready), 64'(4'b1 << (k % 4)));
            sb.push_back('{id: 2'(k % 4), y: 32'((k % 4 + 1) * (k % 4 + 1))});
            if (k > 0) check("fair_spacing", 64'(cyc - last), 64'd3);
            last = cyc;
            @(posedge clk); #1;
        end
        req_valid = '0;
        repeat (3) @(posedge clk);
        #1;

        // Backpressure with an all-ones operand pair and a competing request
        man_ready = 1'b0;
        issue(2, 16'hFFFF, 16'hFFFF, 1'b1, 32'hFFFE0001, acc);
        @(posedge clk); #1;
        req_a[48 +: 16] = 16'h0000;
        req_b[48 +: 16] = 16'hBEEF;
        req_valid[3] = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            check("bp_valid", 64'(rsp_valid), 64'd1);
            check("bp_y", 64'(rsp_y), 64'hFFFE0001);
            check("bp_id", 64'(rsp_id), 64'd2);
            check("bp_req_ready", 64'(req_ready), 64'd0);
            @(posedge clk); #1;
        end
        man_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 64'(rsp_valid), 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_next_grant", 64'(req_ready), 64'b1000);
        if (req_ready[3]) sb.push_back('{id: 2'd3, y: 32'h00000000});
        @(posedge clk); #1;
        req_valid[3] = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        issue(0, 16'h8000, 16'h0002, 1'b1, 32'h00010000, acc);
        repeat (3) @(posedge clk);
        #1;

        // Reset during MUL drops the operation and rewinds the pointer
        issue(1, 16'h1111, 16'h2222, 1'b0, 32'h0, acc);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", 64'(rsp_valid), 64'd0);
        check("mid_rst_y", 64'(rsp_y), 64'd0);
        check("mid_rst_ready", 64'(req_ready), 64'd0);
        check("mid_rst_id", 64'(rsp_id), 64'd0);
        repeat (6) @(posedge clk);
        #1;
        req_a[0 +: 16]  = 16'd3;
        req_b[0 +: 16]  = 16'd5;
        req_a[32 +: 16] = 16'd7;
        req_b[32 +: 16] = 16'd9;
        req_valid = 4'b0101;
        @(negedge clk);
        check("post_rst_grant", 64'(req_ready), 64'b0001);
        if (req_ready[0]) sb.push_back('{id: 2'd0, y: 32'd15});
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        issue(2, 16'd7, 16'd9, 1'b1, 32'd63, acc);
        repeat (3) @(posedge clk);
        #1;

        // Random operands, requesters and response stalls
        rand_mode = 1'b1;
        for (int t = 0; t < 1000; t++) begin
            rid = $urandom_range(0, 3);
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            issue(rid, ra, rb, 1'b1, 32'(ra) * 32'(rb), acc);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        rand_mode = 1'b0;
        man_ready = 1'b1;
        for (int n = 0; n < 100 && sb.size() != 0; n++) begin
            @(posedge clk);
        end
        #1;
        check("drain_pending", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/dadda_mul_arbiter.md
# dadda_mul_arbiter

Round-robin arbiter and sequencer that shares one combinational `Dadda_16b` multiplier instance among `NREQ` requesters. The block accepts one operand pair at a time over a valid/ready handshake and registers the operands in front of the multiplier. It also registers the 32-bit product behind the multiplier and returns it on a single response channel tagged with the requester ID. It sits between the requesting datapath blocks and the shared multiplier and owns the only `Dadda_16b` instance.

## Interface
- `NREQ`, default 4: number of requesters; legal range 2..8.
- `IDW`, default 2: requester-ID width; must satisfy 2^IDW >= NREQ.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `req_valid` input NREQ: bit i set when requester i presents an operand pair.
- `req_ready` output NREQ: one-hot grant; bit i set means requester i's pair is accepted this cycle.
- `req_a` input 16*NREQ: operand A; requester i uses bits [16i+15:16i].
- `req_b` input 16*NREQ: operand B; same packing as `req_a`.
- `rsp_valid` output 1: result available.
- `rsp_ready` input 1: consumer accepts the result.
- `rsp_id` output IDW: index of the requester that owns `rsp_y`.
- `rsp_y` output 32: unsigned product A*B.

## Operation
- The FSM has three states: IDLE, MUL, RESP. Reset state is IDLE.
- **IDLE**
  - If any `req_valid` bit is set, grant exactly one requester, g, and assert `req_ready[g]` combinationally in this cycle.
  - Requester g is the first set bit found by scanning upward (with wrap) from `ptr`.
  - On the clock edge, latch `req_a` and `req_b` of requester g into the operand registers, latch g into the ID register, set `ptr` to (g+1) mod NREQ, and go to MUL.
  - If no `req_valid` bit is set, stay in IDLE and hold all `req_ready` bits low.
- **MUL**
  - The operand registers drive the `Dadda_16b` inputs.
  - On the clock edge, register the 32-bit product into `rsp_y` and go to RESP.
- **RESP**
  - `rsp_valid`=1 and `rsp_y`/`rsp_id` are held stable.
  - When `rsp_valid`&`rsp_ready`, go to IDLE on that edge.
  - Otherwise stay in RESP indefinitely (backpressure). No new request is accepted while in RESP.
- `req_ready` is all-zero in MUL and RESP.
- **Requester obligations:** once `req_valid[i]` is raised, the requester holds it and its operands stable until `req_ready[i]`. `req_valid` must not depend combinationally on `req_ready`.
- **Arithmetic:** unsigned 16x16 to 32-bit, no truncation or saturation.
- **Round-robin pointer**
  - `ptr` (IDW bits) resets to 0, so requester 0 has highest priority after reset.
  - After each grant, the requester just granted has lowest priority.
- **Reset** (any cycle, including mid-MUL or mid-RESP):
  - The state machine goes to IDLE and the in-flight operation is discarded with no response.
  - `ptr`=0, operand and ID registers=0, `rsp_y`=0, `rsp_id`=0, `rsp_valid`=0, `req_ready`=0.

## Timing
- Accept edge T0 (`req_valid[g]`&`req_ready[g]` in IDLE): MUL during cycle T0+1, RESP from T0+2.
- `rsp_valid` rises 2 cycles after acceptance.
- Earliest next grant is the cycle after the response handshake. Maximum throughput is 1 product per 3 cycles when `rsp_ready` is held high.
- If `rsp_ready` is already 1 when RESP is entered, `rsp_valid` is high for exactly 1 cycle.
- The combinational path runs from the operand registers through `Dadda_16b` to the `rsp_y` register, a one-cycle budget. No input-to-output combinational path exists except `req_valid` to `req_ready`.

## Test plan
- **Single request after reset:** requester 1, A=0x1234, B=0x5678, `rsp_ready`=1.
  - `req_ready`=4'b0010 in the accept cycle.
  - 2 cycles later `rsp_valid`=1, `rsp_id`=1, `rsp_y`=0x06260060, for exactly 1 cycle.
- **Boundary operands:**
  - 0xFFFF*0xFFFF gives 0xFFFE0001.
  - 0x0000*0xBEEF gives 0x00000000.
  - 0x8000*0x0002 gives 0x00010000.
- **Fairness:** all 4 requesters held valid continuously, each with A=B=its index+1.
  - Grant order is 0,1,2,3,0.
  - `rsp_y` sequence is 1,4,9,16,1.
  - Exactly 3 cycles between accepts.
- **Backpressure:** `rsp_ready`=0 for 5 cycles in RESP.
  - `rsp_valid`, `rsp_y` and `rsp_id` stay stable.
  - `req_ready`=0 throughout.
  - The next grant occurs the cycle after `rsp_ready` rises.
- **Reset mid-operation:** assert `rst` during MUL.
  - Next cycle: `rsp_valid`=0, `rsp_y`=0, `req_ready`=0.
  - No response is ever produced for the dropped request.
  - A subsequent request from requester 2 with requester 0 also valid is granted to 0, because `ptr` is 0.
- **Randomized comparison:** 1000 random operand pairs from random requesters with random `rsp_ready` stalls.
  - Every response matches A*B and its ID.
  - No request is lost or duplicated.
